shared_debounce_ctrl: RTL and testbench
=======================================

SHARED_DEBOUNCE_CTRL -- requirements
Module: shared_debounce_ctrl

Interface
REQ-001 SHALL have parameter SYS_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TIME_LAPES, default 10, debounce duration in TIME_BASE units.
REQ-003 SHALL have parameter TIME_BASE, default 1000, time unit divisor (1000 = ms, 1_000_000 = us).
REQ-004 SHALL have parameter NUM_SW, default 4, number of switch inputs; legal range is NUM_SW >= 2.
REQ-005 SHALL derive COUNTER = SYS_FREQ/TIME_BASE*TIME_LAPES (legal range COUNTER >= 2), N = $clog2(COUNTER) and IW = $clog2(NUM_SW).
REQ-006 SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, asynchronous active-low reset; rst = 0 resets immediately, with no clock edge required.
REQ-008 SHALL have port sw, input, NUM_SW bits, raw asynchronous switch levels.
REQ-009 SHALL have port deb, output, NUM_SW bits, debounced levels.
REQ-010 SHALL have port press_tick, output, NUM_SW bits, one-cycle pulse when deb[i] goes 0 to 1.
REQ-011 SHALL have port release_tick, output, NUM_SW bits, one-cycle pulse when deb[i] goes 1 to 0.
REQ-012 SHALL have port busy, output, 1 bit, high while the shared timer is allocated to a switch.
REQ-013 SHALL have port active_idx, output, IW bits, index of the switch currently owning the timer.

Function
REQ-014 SHALL pass each sw[i] through a two-flop synchronizer; sync[i] denotes the second-flop output.
REQ-015 SHALL share one N-bit counter cnt among all switches, using states IDLE, COUNT and DONE.
REQ-016 IDLE: SHALL select the first index i, searching round-robin from ptr upward with wrap, for which sync[i] != deb[i]; the next state is COUNT with sel = i, cnt = 0.
REQ-017 IDLE: SHALL remain in IDLE with cnt held at 0 when no index has a mismatch.
REQ-018 COUNT abort: SHALL return to IDLE with deb unchanged and ptr = (sel+1) mod NUM_SW when sync[sel] == deb[sel].
REQ-019 COUNT expiry: SHALL, when cnt == COUNTER-1 and sync[sel] != deb[sel], set deb[sel] <= sync[sel], assert the matching tick bit, and go to DONE.
REQ-020 COUNT otherwise: SHALL increment cnt by 1; cnt never exceeds COUNTER-1.
REQ-021 DONE: SHALL hold press_tick/release_tick high for exactly this one cycle, then go to IDLE with ptr = (sel+1) mod NUM_SW and cnt = 0.
REQ-022 SHALL leave every tick bit other than the committed one at 0; at most one tick bit is high in any cycle.
REQ-023 SHALL keep busy = 1 in COUNT and DONE and busy = 0 in IDLE.
REQ-024 SHALL keep active_idx = sel in COUNT and DONE, and active_idx = ptr in IDLE.
REQ-025 SHALL ignore mismatches on non-selected switches until the FSM returns to IDLE; those switches wait and their deb bits hold.
REQ-026 SHALL make a switch whose level is stable from its first sample update deb exactly COUNTER+3 clock edges after sw changes: 2 synchronizer edges, 1 IDLE edge, COUNTER COUNT edges.
REQ-027 SHALL make deb, press_tick, release_tick, busy and active_idx direct register outputs.
REQ-028 SHALL resolve simultaneous mismatches in round-robin order; the worst-case wait of one switch is (NUM_SW-1)*(COUNTER+2) cycles.
REQ-029 SHALL advance ptr identically on abort and on commit, so that a chattering switch cannot starve the others.

Reset
REQ-030 SHALL, on rst = 0, asynchronously clear the synchronizers, deb, press_tick, release_tick, cnt, sel and ptr, set busy = 0 and active_idx = 0, and enter IDLE.
REQ-031 SHALL, on reset asserted mid-COUNT, discard the count with no deb change and no tick; after release, a switch still held high is re-debounced from IDLE.
REQ-032 SHALL make the first state change after rst deassertion occur on a clock edge only.

Verification (SYS_FREQ=1000, TIME_BASE=1000, TIME_LAPES=4 -> COUNTER=4; NUM_SW=4)
REQ-033 Bench SHALL cover: sw[0] set to 1 and held -> deb[0] = 1 and press_tick[0] high for 1 cycle, 7 edges after the change; busy high for 5 cycles.
REQ-034 Bench SHALL cover: sw[1] 0->1 held 3 cycles then back to 0 -> abort, deb[1] stays 0, no tick, ptr = 2.
REQ-035 Bench SHALL cover: sw = 4'b1111 applied in one cycle from reset -> deb bits commit in order 0,1,2,3, 6 cycles apart, each with one press_tick.
REQ-036 Bench SHALL cover: sw[2] toggling every 2 cycles while sw[3] is held high -> sw[3] commits within 2*(COUNTER+2) cycles; no starvation.
REQ-037 Bench SHALL cover: deb[0] = 1, then sw[0] = 0 held -> release_tick[0] for 1 cycle and deb[0] = 0 after 7 edges.
REQ-038 Bench SHALL cover: rst pulsed low at cnt = 2 during sw[1] = 1 -> all outputs 0 immediately; after release, deb[1] = 1 follows 7 edges later.

Source files
------------

// File: rtl/shared_debounce_ctrl.sv
// Multi-switch debouncer: one shared timer is granted round-robin to whichever
// synchronized switch disagrees with its debounced level.
module shared_debounce_ctrl #(
  parameter  int SYS_FREQ   = 100_000_000,
  parameter  int TIME_LAPES = 10,
  parameter  int TIME_BASE  = 1000,
  parameter  int NUM_SW     = 4,
  localparam int COUNTER    = SYS_FREQ / TIME_BASE * TIME_LAPES,
  localparam int N          = $clog2(COUNTER),
  localparam int IW         = $clog2(NUM_SW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw,
  output logic [NUM_SW-1:0] deb,
  output logic [NUM_SW-1:0] press_tick,
  output logic [NUM_SW-1:0] release_tick,
  output logic              busy,
  output logic [IW-1:0]     active_idx
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t            state, state_n;
  logic [NUM_SW-1:0] sync1, sync, mism;
  logic [NUM_SW-1:0] deb_n, press_n, release_n;
  logic [N-1:0]      cnt, cnt_n;
  logic [IW-1:0]     sel, sel_n, ptr, ptr_n, sel_inc, cand, idx_n;
  logic              busy_n, found;

  assign mism    = sync ^ deb;
  assign sel_inc = (sel == IW'(NUM_SW - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sel_n     = sel;
    ptr_n     = ptr;
    deb_n     = deb;
    press_n   = '0;
    release_n = '0;
    found     = 1'b0;
    cand      = '0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        // First mismatch scanning upward from ptr with wrap-around.
        for (int unsigned k = 0; k < NUM_SW; k++) begin
          cand = IW'((32'(ptr) + k) % NUM_SW);
          if (!found && mism[cand]) begin
            found   = 1'b1;
            sel_n   = cand;
            state_n = COUNT;
          end
        end
      end
      COUNT: begin
        if (!mism[sel]) begin
          state_n = IDLE;
          ptr_n   = sel_inc;
          cnt_n   = '0;
        end else if (cnt == N'(COUNTER - 1)) begin
          deb_n[sel]     = sync[sel];
          press_n[sel]   = sync[sel];
          release_n[sel] = ~sync[sel];
          state_n        = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        ptr_n   = sel_inc;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
    // Status outputs are registered, so derive them from the next state.
    busy_n = (state_n != IDLE);
    idx_n  = busy_n ? sel_n : ptr_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sync1        <= '0;
      sync         <= '0;
      cnt          <= '0;
      sel          <= '0;
      ptr          <= '0;
      deb          <= '0;
      press_tick   <= '0;
      release_tick <= '0;
      busy         <= 1'b0;
      active_idx   <= '0;
    end else begin
      state        <= state_n;
      sync1        <= sw;
      sync         <= sync1;
      cnt          <= cnt_n;
      sel          <= sel_n;
      ptr          <= ptr_n;
      deb          <= deb_n;
      press_tick   <= press_n;
      release_tick <= release_n;
      busy         <= busy_n;
      active_idx   <= idx_n;
    end
  end

endmodule

// File: tb/tb_shared_debounce_ctrl.sv
// Directed bench for shared_debounce_ctrl (COUNTER=4, NUM_SW=4); expectations
// are queued with their due cycle and checked when that cycle arrives.
module tb_shared_debounce_ctrl;

  localparam int K_DEB = 0, K_PRS = 1, K_REL = 2, K_BSY = 3, K_IDX = 4;

  logic       clk, rst;
  logic [3:0] sw, deb, press_tick, release_tick;
  logic       busy;
  logic [1:0] active_idx;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [7:0]  exp;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc   = 0;
  int unsigned nvec  = 0;
  int unsigned nfail = 0;

  shared_debounce_ctrl #(
    .SYS_FREQ  (1000),
    .TIME_LAPES(4),
    .TIME_BASE (1000),
    .NUM_SW    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .deb         (deb),
    .press_tick  (press_tick),
    .release_tick(release_tick),
    .busy        (busy),
    .active_idx  (active_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] obs_of(input int kind);
    case (kind)
      K_DEB:   return 8'(deb);
      K_PRS:   return 8'(press_tick);
      K_REL:   return 8'(release_tick);
      K_BSY:   return 8'(busy);
      default: return 8'(active_idx);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int unsigned d, input int kind, input logic [7:0] v, input string tag);
    sb.push_back('{cyc + d, kind, v, tag});
  endtask

  task automatic run(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          chk(sb[i].tag, obs_of(sb[i].kind), sb[i].exp);
          sb.delete(i);
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_deb"},  obs_of(K_DEB), 8'h0);
    chk({tag, "_prs"},  obs_of(K_PRS), 8'h0);
    chk({tag, "_rel"},  obs_of(K_REL), 8'h0);
    chk({tag, "_busy"}, obs_of(K_BSY), 8'h0);
    chk({tag, "_idx"},  obs_of(K_IDX), 8'h0);
  endtask

  initial begin
    logic b;
    rst = 1'b0;
    sw  = 4'b0000;
    run(2);
    chk_all_zero("reset");
    rst = 1'b1;
    run(3);

    // Press on switch 0: commit on the 7th edge, busy for 5 cycles.
    sw = 4'b0001;
    push_exp(6, K_DEB, 8'h0, "A_deb_pre");
    push_exp(7, K_DEB, 8'h1, "A_deb_commit");
    push_exp(6, K_PRS, 8'h0, "A_prs_pre");
    push_exp(7, K_PRS, 8'h1, "A_prs_pulse");
    push_exp(8, K_PRS, 8'h0, "A_prs_end");
    push_exp(2, K_BSY, 8'h0, "A_busy_pre");
    push_exp(3, K_BSY, 8'h1, "A_busy_start");
    push_exp(7, K_BSY, 8'h1, "A_busy_done");
    push_exp(8, K_BSY, 8'h0, "A_busy_end");
    push_exp(3, K_IDX, 8'h0, "A_idx_sel");
    push_exp(8, K_IDX, 8'h1, "A_idx_ptr");
    run(10);

    // Glitch on switch 1 lasting 3 cycles: abort, no tick, ptr moves to 2.
    sw = 4'b0011;
    push_exp(2, K_BSY, 8'h0, "B_busy_pre");
    push_exp(3, K_BSY, 8'h1, "B_busy_start");
    push_exp(5, K_BSY, 8'h1, "B_busy_hold");
    push_exp(6, K_BSY, 8'h0, "B_busy_abort");
    push_exp(3, K_IDX, 8'h1, "B_idx_sel");
    push_exp(6, K_IDX, 8'h2, "B_idx_ptr");
    for (int unsigned d = 3; d <= 10; d++) push_exp(d, K_PRS, 8'h0, "B_no_tick");
    push_exp(10, K_DEB, 8'h1, "B_deb_hold");
    run(3);
    sw = 4'b0001;
    run(7);

    // Release of switch 0, found by wrapping the search from ptr=2.
    sw = 4'b0000;
    push_exp(3, K_IDX, 8'h0, "C_idx_sel");
    push_exp(6, K_DEB, 8'h1, "C_deb_pre");
    push_exp(7, K_DEB, 8'h0, "C_deb_commit");
    push_exp(6, K_REL, 8'h0, "C_rel_pre");
    push_exp(7, K_REL, 8'h1, "C_rel_pulse");
    push_exp(8, K_REL, 8'h0, "C_rel_end");
    push_exp(8, K_BSY, 8'h0, "C_busy_end");
    push_exp(8, K_IDX, 8'h1, "C_idx_ptr");
    run(10);

    // All four switches at once from reset: commits 6 cycles apart in order.
    rst = 1'b0;
    run(1);
    rst = 1'b1;
    sw  = 4'b1111;
    push_exp(6,  K_DEB, 8'h0, "D_deb_pre");
    push_exp(7,  K_DEB, 8'h1, "D_deb0");
    push_exp(12, K_DEB, 8'h1, "D_deb1_pre");
    push_exp(13, K_DEB, 8'h3, "D_deb1");
    push_exp(19, K_DEB, 8'h7, "D_deb2");
    push_exp(25, K_DEB, 8'hF, "D_deb3");
    push_exp(7,  K_PRS, 8'h1, "D_prs0");
    push_exp(8,  K_PRS, 8'h0, "D_prs0_end");
    push_exp(13, K_PRS, 8'h2, "D_prs1");
    push_exp(19, K_PRS, 8'h4, "D_prs2");
    push_exp(25, K_PRS, 8'h8, "D_prs3");
    push_exp(9,  K_IDX, 8'h1, "D_idx1");
    push_exp(15, K_IDX, 8'h2, "D_idx2");
    push_exp(21, K_IDX, 8'h3, "D_idx3");
    run(28);

    // Reset mid-count on switch 1, then re-debounce from scratch.
    rst = 1'b0;
    sw  = 4'b0000;
    run(1);
    rst = 1'b1;
    run(3);
    sw = 4'b0010;
    push_exp(3, K_BSY, 8'h1, "E_busy_start");
    push_exp(5, K_BSY, 8'h1, "E_busy_cnt2");
    run(5);
    rst = 1'b0;
    #1;
    chk_all_zero("E_async_rst");
    run(1);
    rst = 1'b1;
    push_exp(2, K_BSY, 8'h0, "E_busy_pre");
    push_exp(3, K_BSY, 8'h1, "E_busy_restart");
    push_exp(6, K_DEB, 8'h0, "E_deb_pre");
    push_exp(7, K_DEB, 8'h2, "E_deb_commit");
    push_exp(7, K_PRS, 8'h2, "E_prs_pulse");
    run(9);

    // Switch 2 chatters every 2 cycles; switch 3 must still get served.
    push_exp(3,  K_IDX, 8'h2, "F_idx_chatter");
    push_exp(5,  K_BSY, 8'h0, "F_busy_abort");
    push_exp(5,  K_IDX, 8'h3, "F_idx_ptr");
    push_exp(5,  K_PRS, 8'h0, "F_no_tick");
    push_exp(6,  K_BSY, 8'h1, "F_busy_sw3");
    push_exp(9,  K_DEB, 8'h2, "F_deb_pre");
    push_exp(10, K_DEB, 8'hA, "F_deb3_commit");
    push_exp(10, K_PRS, 8'h8, "F_prs3");
    b = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      sw = {1'b1, b, 1'b1, 1'b0};
      run(2);
      b = ~b;
    end
    run(2);

    chk("scoreboard_drained", 8'(sb.size()), 8'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
